// File: rtl/dcache_line_bridge.sv
// dcache_line_bridge
// Memory-side responder for the data cache refill/write-back port. Each
// 256-bit line request becomes one 8-beat, 32-bit AXI4 INCR burst. Only one
// transaction is in flight at a time.
module dcache_line_bridge #(
   parameter bit WRITE_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   // dcache side
   input  logic         rd_req,
   input  logic [31:0]  rd_addr,
   output logic         rd_rdy,
   output logic         ret_valid,
   output logic [255:0] ret_data,
   input  logic         wr_req,
   input  logic [31:0]  wr_addr,
   input  logic [255:0] wr_data,
   output logic         wr_rdy,
   output logic         data_bvalid_o,
   // AXI read channels
   output logic [31:0]  araddr,
   output logic [7:0]   arlen,
   output logic         arvalid,
   input  logic         arready,
   input  logic [31:0]  rdata,
   input  logic         rlast,
   input  logic         rvalid,
   output logic         rready,
   // AXI write channels
   output logic [31:0]  awaddr,
   output logic [7:0]   awlen,
   output logic         awvalid,
   input  logic         awready,
   output logic [31:0]  wdata,
   output logic [3:0]   wstrb,
   output logic         wlast,
   output logic         wvalid,
   input  logic         wready,
   input  logic         bvalid,
   output logic         bready
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AR   = 3'd1;
   localparam logic [2:0] S_R    = 3'd2;
   localparam logic [2:0] S_AW   = 3'd3;
   localparam logic [2:0] S_W    = 3'd4;
   localparam logic [2:0] S_B    = 3'd5;

   logic [2:0]   state;
   logic [31:0]  addr_q;
   logic [255:0] line_buf;
   logic [2:0]   cnt;
   logic         is_idle;
   logic         rd_acc;
   logic         wr_acc;
   logic         unused_addr_bits;

   // The low five address bits select a byte inside the line and are dropped.
   assign unused_addr_bits = ^{rd_addr[4:0], wr_addr[4:0]};

   // The ready terms are forced low while reset is held so that every output
   // reads zero during reset; the completion pulses block a same-cycle accept.
   assign is_idle = (state == S_IDLE);
   assign rd_rdy  = reset & is_idle & ~ret_valid & ~data_bvalid_o & ~(WRITE_FIRST & wr_req);
   assign wr_rdy  = reset & is_idle & ~ret_valid & ~data_bvalid_o & ~(~WRITE_FIRST & rd_req);
   assign rd_acc  = rd_req & rd_rdy;
   assign wr_acc  = wr_req & wr_rdy;

   // Address and write payload come straight from registers that only change
   // on accept or on an accepted beat, which keeps AXI payloads stable.
   assign araddr  = addr_q;
   assign awaddr  = addr_q;
   assign arlen   = 8'd7;
   assign awlen   = 8'd7;
   assign wstrb   = 4'hF;
   assign arvalid = (state == S_AR);
   assign rready  = (state == S_R);
   assign awvalid = (state == S_AW);
   assign wvalid  = (state == S_W);
   assign wlast   = (state == S_W) && (cnt == 3'd7);
   assign bready  = (state == S_B);
   assign wdata   = line_buf[{cnt, 5'd0} +: 32];

   // Control FSM: latches the request on accept and walks the AXI channels.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         addr_q   <= '0;
         line_buf <= '0;
         cnt      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (wr_acc) begin
                  state    <= S_AW;
                  addr_q   <= {wr_addr[31:5], 5'd0};
                  line_buf <= wr_data;
                  cnt      <= '0;
               end else if (rd_acc) begin
                  state  <= S_AR;
                  addr_q <= {rd_addr[31:5], 5'd0};
                  cnt    <= '0;
               end
            end
            S_AR: begin
               if (arready) state <= S_R;
            end
            S_R: begin
               if (rvalid) begin
                  cnt <= cnt + 3'd1;
                  if (rlast) state <= S_IDLE;
               end
            end
            S_AW: begin
               if (awready) state <= S_W;
            end
            S_W: begin
               if (wready) begin
                  cnt <= cnt + 3'd1;
                  if (cnt == 3'd7) state <= S_B;
               end
            end
            S_B: begin
               if (bvalid) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Refill assembly and the one-cycle completion pulses; rlast closes the
   // line early and any words not received keep their previous contents.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ret_data      <= '0;
         ret_valid     <= 1'b0;
         data_bvalid_o <= 1'b0;
      end else begin
         ret_valid     <= (state == S_R) && rvalid && rlast;
         data_bvalid_o <= (state == S_B) && bvalid;
         if ((state == S_R) && rvalid) begin
            ret_data[{cnt, 5'd0} +: 32] <= rdata;
         end
      end
   end

endmodule

// File: tb/tb_dcache_line_bridge.sv
// tb_dcache_line_bridge
// Directed self-checking bench: one task per scenario, inline comparisons.
module tb_dcache_line_bridge;

   logic         clk = 1'b0;
   logic         reset;
   logic         rd_req;
   logic [31:0]  rd_addr;
   logic         rd_rdy;
   logic         ret_valid;
   logic [255:0] ret_data;
   logic         wr_req;
   logic [31:0]  wr_addr;
   logic [255:0] wr_data;
   logic         wr_rdy;
   logic         data_bvalid_o;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic         arvalid;
   logic         arready;
   logic [31:0]  rdata;
   logic         rlast;
   logic         rvalid;
   logic         rready;
   logic [31:0]  awaddr;
   logic [7:0]   awlen;
   logic         awvalid;
   logic         awready;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wlast;
   logic         wvalid;
   logic         wready;
   logic         bvalid;
   logic         bready;

   int n_checks = 0;
   int n_fail   = 0;

   dcache_line_bridge #(.WRITE_FIRST(1'b1)) dut (
      .clk(clk), .reset(reset),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
      .ret_valid(ret_valid), .ret_data(ret_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
      .data_bvalid_o(data_bvalid_o),
      .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish (actual running, required finished)");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clear_inputs();
      rd_req  = 1'b0; rd_addr = '0;
      wr_req  = 1'b0; wr_addr = '0; wr_data = '0;
      arready = 1'b0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clear_inputs();
      #3;
      n_checks++;
      if ({rd_rdy, wr_rdy, ret_valid, data_bvalid_o, arvalid, rready, awvalid, wvalid, wlast, bready} !== 10'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_ctrl: got %b expected 0", {rd_rdy, wr_rdy, ret_valid, data_bvalid_o, arvalid, rready, awvalid, wvalid, wlast, bready});
      end
      n_checks++;
      if (ret_data !== 256'd0) begin
         n_fail++; $display("[TB] FAIL reset_ret_data: got %h expected 0", ret_data);
      end
      n_checks++;
      if ({araddr, awaddr, wdata} !== 96'd0) begin
         n_fail++; $display("[TB] FAIL reset_payload: got %h expected 0", {araddr, awaddr, wdata});
      end
      n_checks++;
      if ({arlen, awlen, wstrb} !== {8'd7, 8'd7, 4'hF}) begin
         n_fail++; $display("[TB] FAIL reset_consts: got %h expected 07_07_f", {arlen, awlen, wstrb});
      end
      @(posedge clk);
      #3;
      reset = 1'b1;
      next_cycle();
   endtask

   task automatic test_read_burst();
      logic [255:0] exp_line;
      int pulses;
      pulses = 0;
      for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'h100 + i;
      next_cycle();
      rd_req = 1'b1; rd_addr = 32'h1C00_0044;
      settle();
      n_checks++;
      if (rd_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_accept: rd_rdy got %b expected 1", rd_rdy); end
      next_cycle();
      arready = 1'b1;
      settle();
      n_checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h1C00_0040 || arlen !== 8'd7) begin
         n_fail++; $display("[TB] FAIL rd_ar: got v=%b a=%h l=%0d expected v=1 a=1c000040 l=7", arvalid, araddr, arlen);
      end
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         arready = 1'b0; rvalid = 1'b1; rdata = 32'h100 + i; rlast = (i == 7);
         settle();
         if (ret_valid) pulses++;
         n_checks++;
         if (rready !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_rready beat %0d: got %b expected 1", i, rready); end
      end
      next_cycle();
      rvalid = 1'b0; rlast = 1'b0; rd_req = 1'b0;
      settle();
      n_checks++;
      if (ret_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_ret_valid T+10: got %b expected 1", ret_valid); end
      n_checks++;
      if (ret_data !== exp_line) begin n_fail++; $display("[TB] FAIL rd_ret_data: got %h expected %h", ret_data, exp_line); end
      n_checks++;
      if (rd_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_rdy_during_pulse: got %b expected 0", rd_rdy); end
      next_cycle();
      settle();
      n_checks++;
      if (ret_valid !== 1'b0 || pulses != 0) begin
         n_fail++; $display("[TB] FAIL rd_single_pulse: got after=%b early=%0d expected 0 and 0", ret_valid, pulses);
      end
   endtask

   task automatic test_write_burst();
      int k;
      int cyc;
      k = 0; cyc = 0;
      next_cycle();
      wr_req = 1'b1; wr_addr = 32'h0000_2FFF;
      for (int i = 0; i < 8; i++) wr_data[32*i +: 32] = 32'hA0 + i;
      settle();
      n_checks++;
      if (wr_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_accept: wr_rdy got %b expected 1", wr_rdy); end
      next_cycle();
      awready = 1'b1;
      settle();
      n_checks++;
      if (awvalid !== 1'b1 || awaddr !== 32'h0000_2FE0 || awlen !== 8'd7) begin
         n_fail++; $display("[TB] FAIL wr_aw: got v=%b a=%h l=%0d expected v=1 a=00002fe0 l=7", awvalid, awaddr, awlen);
      end
      while (k < 8 && cyc < 40) begin
         next_cycle();
         awready = 1'b0;
         wready = (cyc % 2 == 1);
         settle();
         n_checks++;
         if (wvalid !== 1'b1 || wdata !== 32'hA0 + k || wstrb !== 4'hF) begin
            n_fail++; $display("[TB] FAIL wr_beat %0d: got v=%b d=%h s=%h expected v=1 d=%h s=f", k, wvalid, wdata, wstrb, 32'hA0 + k);
         end
         n_checks++;
         if (wlast !== (k == 7)) begin n_fail++; $display("[TB] FAIL wr_wlast beat %0d: got %b expected %b", k, wlast, (k == 7)); end
         if (wready) k++;
         cyc++;
      end
      n_checks++;
      if (k != 8) begin n_fail++; $display("[TB] FAIL wr_beat_count: got %0d expected 8", k); end
      next_cycle();
      wready = 1'b0;
      settle();
      n_checks++;
      if (bready !== 1'b1 || wvalid !== 1'b0 || data_bvalid_o !== 1'b0) begin
         n_fail++; $display("[TB] FAIL wr_b_wait: got br=%b wv=%b pulse=%b expected 1 0 0", bready, wvalid, data_bvalid_o);
      end
      next_cycle();
      bvalid = 1'b1;
      settle();
      next_cycle();
      bvalid = 1'b0; wr_req = 1'b0;
      settle();
      n_checks++;
      if (data_bvalid_o !== 1'b1 || wr_rdy !== 1'b0) begin
         n_fail++; $display("[TB] FAIL wr_bvalid_pulse: got pulse=%b rdy=%b expected 1 0", data_bvalid_o, wr_rdy);
      end
      next_cycle();
      settle();
      n_checks++;
      if (data_bvalid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_pulse_width: got %b expected 0", data_bvalid_o); end
   endtask

   task automatic test_simultaneous();
      logic [255:0] exp_line;
      int stray;
      stray = 0;
      for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'h200 + i;
      next_cycle();
      rd_req = 1'b1; rd_addr = 32'h0000_5000;
      wr_req = 1'b1; wr_addr = 32'h0000_6000;
      for (int i = 0; i < 8; i++) wr_data[32*i +: 32] = 32'hB0 + i;
      settle();
      n_checks++;
      if (wr_rdy !== 1'b1 || rd_rdy !== 1'b0) begin
         n_fail++; $display("[TB] FAIL sim_priority: got wr_rdy=%b rd_rdy=%b expected 1 0", wr_rdy, rd_rdy);
      end
      next_cycle();
      awready = 1'b1;
      settle();
      n_checks++;
      if (awvalid !== 1'b1 || arvalid !== 1'b0 || awaddr !== 32'h0000_6000) begin
         n_fail++; $display("[TB] FAIL sim_aw_first: got awv=%b arv=%b a=%h expected 1 0 00006000", awvalid, arvalid, awaddr);
      end
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         awready = 1'b0; wready = 1'b1;
         settle();
         if (arvalid) stray++;
         n_checks++;
         if (wdata !== 32'hB0 + i) begin n_fail++; $display("[TB] FAIL sim_wdata %0d: got %h expected %h", i, wdata, 32'hB0 + i); end
      end
      next_cycle();
      wready = 1'b0; bvalid = 1'b1;
      settle();
      if (arvalid) stray++;
      next_cycle();
      bvalid = 1'b0; wr_req = 1'b0;
      settle();
      n_checks++;
      if (data_bvalid_o !== 1'b1 || rd_rdy !== 1'b0 || arvalid !== 1'b0) begin
         n_fail++; $display("[TB] FAIL sim_wr_done: got pulse=%b rd_rdy=%b arv=%b expected 1 0 0", data_bvalid_o, rd_rdy, arvalid);
      end
      next_cycle();
      settle();
      n_checks++;
      if (rd_rdy !== 1'b1 || stray != 0) begin
         n_fail++; $display("[TB] FAIL sim_rd_after: got rd_rdy=%b early_ar=%0d expected 1 0", rd_rdy, stray);
      end
      next_cycle();
      arready = 1'b1;
      settle();
      n_checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h0000_5000) begin
         n_fail++; $display("[TB] FAIL sim_ar: got v=%b a=%h expected 1 00005000", arvalid, araddr);
      end
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         arready = 1'b0; rvalid = 1'b1; rdata = 32'h200 + i; rlast = (i == 7);
         settle();
      end
      next_cycle();
      rvalid = 1'b0; rlast = 1'b0; rd_req = 1'b0;
      settle();
      n_checks++;
      if (ret_valid !== 1'b1 || ret_data !== exp_line) begin
         n_fail++; $display("[TB] FAIL sim_rd_done: got v=%b d=%h expected 1 %h", ret_valid, ret_data, exp_line);
      end
   endtask

   task automatic test_short_read();
      logic [255:0] exp_line;
      for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'h200 + i;
      for (int i = 0; i < 3; i++) exp_line[32*i +: 32] = 32'h300 + i;
      next_cycle();
      rd_req = 1'b1; rd_addr = 32'h7000_001F;
      settle();
      n_checks++;
      if (rd_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL short_accept: rd_rdy got %b expected 1", rd_rdy); end
      next_cycle();
      settle();
      next_cycle();
      arready = 1'b1;
      settle();
      n_checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h7000_0000) begin
         n_fail++; $display("[TB] FAIL short_ar_stall: got v=%b a=%h expected 1 70000000", arvalid, araddr);
      end
      next_cycle();
      arready = 1'b0; rvalid = 1'b1; rdata = 32'h300;
      settle();
      next_cycle();
      rvalid = 1'b0; rdata = 32'hDEAD_BEEF;
      settle();
      n_checks++;
      if (ret_valid !== 1'b0 || rready !== 1'b1) begin
         n_fail++; $display("[TB] FAIL short_r_stall: got v=%b rready=%b expected 0 1", ret_valid, rready);
      end
      next_cycle();
      rvalid = 1'b1; rdata = 32'h301;
      settle();
      next_cycle();
      rdata = 32'h302; rlast = 1'b1;
      settle();
      next_cycle();
      rvalid = 1'b0; rlast = 1'b0; rd_req = 1'b0;
      settle();
      n_checks++;
      if (ret_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL short_ret_valid: got %b expected 1", ret_valid); end
      n_checks++;
      if (ret_data !== exp_line) begin n_fail++; $display("[TB] FAIL short_ret_data: got %h expected %h", ret_data, exp_line); end
      next_cycle();
      settle();
      n_checks++;
      if (ret_valid !== 1'b0 || rready !== 1'b0) begin
         n_fail++; $display("[TB] FAIL short_idle: got v=%b rready=%b expected 0 0", ret_valid, rready);
      end
   endtask

   task automatic test_reset_mid_write();
      logic [255:0] exp_line;
      int pulses;
      pulses = 0;
      for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'h400 + i;
      next_cycle();
      wr_req = 1'b1; wr_addr = 32'h8000_0040;
      for (int i = 0; i < 8; i++) wr_data[32*i +: 32] = 32'hC0 + i;
      settle();
      next_cycle();
      awready = 1'b1;
      settle();
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         awready = 1'b0; wready = 1'b1;
         settle();
      end
      next_cycle();
      wready = 1'b0;
      settle();
      n_checks++;
      if (wvalid !== 1'b1 || wdata !== 32'hC4) begin
         n_fail++; $display("[TB] FAIL rst_beat4: got v=%b d=%h expected 1 000000c4", wvalid, wdata);
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if ({rd_rdy, wr_rdy, ret_valid, data_bvalid_o, arvalid, rready, awvalid, wvalid, wlast, bready} !== 10'b0) begin
         n_fail++;
         $display("[TB] FAIL rst_ctrl: got %b expected 0", {rd_rdy, wr_rdy, ret_valid, data_bvalid_o, arvalid, rready, awvalid, wvalid, wlast, bready});
      end
      n_checks++;
      if ({araddr, awaddr, wdata} !== 96'd0 || ret_data !== 256'd0) begin
         n_fail++; $display("[TB] FAIL rst_payload: got %h ret=%h expected 0", {araddr, awaddr, wdata}, ret_data);
      end
      wr_req = 1'b0;
      next_cycle();
      settle();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         bvalid = (i == 0);
         settle();
         if (data_bvalid_o || bready) pulses++;
      end
      bvalid = 1'b0;
      n_checks++;
      if (pulses != 0) begin n_fail++; $display("[TB] FAIL rst_no_bpulse: got %0d cycles active expected 0", pulses); end
      next_cycle();
      rd_req = 1'b1; rd_addr = 32'h0000_0180;
      settle();
      n_checks++;
      if (rd_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_rd_accept: rd_rdy got %b expected 1", rd_rdy); end
      next_cycle();
      arready = 1'b1;
      settle();
      n_checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h0000_0180) begin
         n_fail++; $display("[TB] FAIL rst_rd_ar: got v=%b a=%h expected 1 00000180", arvalid, araddr);
      end
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         arready = 1'b0; rvalid = 1'b1; rdata = 32'h400 + i; rlast = (i == 7);
         settle();
      end
      next_cycle();
      rvalid = 1'b0; rlast = 1'b0; rd_req = 1'b0;
      settle();
      n_checks++;
      if (ret_valid !== 1'b1 || ret_data !== exp_line) begin
         n_fail++; $display("[TB] FAIL rst_rd_done: got v=%b d=%h expected 1 %h", ret_valid, ret_data, exp_line);
      end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_read_burst();
      test_write_burst();
      test_simultaneous();
      test_short_read();
      test_reset_mid_write();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dcache_line_bridge.md
# dcache_line_bridge

Memory-side responder for the data cache's line-refill/write-back interface. It accepts one 256-bit line read (`rd_req`) or line write (`wr_req`) at a time from `dcache` and turns it into a single 8-beat, 32-bit AXI4 INCR burst on the master port toward the interconnect. It returns refill data as one 256-bit `ret_data` pulse and acknowledges write-back completion with `data_bvalid_o`. It sits between `dcache` and the top-level AXI crossbar.

## Interface

- `WRITE_FIRST`, default 1: when `rd_req` and `wr_req` are both pending in IDLE, 1 serves the write first and 0 serves the read first.
- `clk` in 1: clock. All logic is on the rising edge.
- `reset` in 1: reset, **asynchronous and active-low**. The clock and reset port names follow the codebase; polarity and synchronicity are fixed.
- `rd_req` in 1: line read request. It is held until `ret_valid`.
- `rd_addr` in 32: physical read address. Bits [4:0] are ignored.
- `rd_rdy` out 1: the bridge can accept a read.
- `ret_valid` out 1: one-cycle pulse; `ret_data` is valid.
- `ret_data` out 256: refill line. Word i occupies [32i+31:32i].
- `wr_req` in 1: line write request. It is held until `data_bvalid_o`.
- `wr_addr` in 32: physical write address. Bits [4:0] are ignored.
- `wr_data` in 256: victim line. Word i occupies [32i+31:32i].
- `wr_rdy` out 1: the bridge can accept a write.
- `data_bvalid_o` out 1: one-cycle pulse; the write-back is complete.
- `araddr` out 32: line-aligned read address.
- `arlen` out 8: constant 7.
- `arvalid` out 1: AR valid.
- `arready` in 1: AR ready.
- `rdata` in 32: read beat data.
- `rlast` in 1: last read beat.
- `rvalid` in 1: R valid.
- `rready` out 1: R ready.
- `awaddr` out 32: line-aligned write address.
- `awlen` out 8: constant 7.
- `awvalid` out 1: AW valid.
- `awready` in 1: AW ready.
- `wdata` out 32: current write beat.
- `wstrb` out 4: constant 4'hF.
- `wlast` out 1: high on beat 7.
- `wvalid` out 1: W valid.
- `wready` in 1: W ready.
- `bvalid` in 1: B valid.
- `bready` out 1: B ready.

Size and burst type are fixed at 4 bytes and INCR and are tied off at the top level. Response codes are not checked.

## Operation

- **States:** IDLE, AR, R, AW, W, B. There is one transaction at a time, so reads and writes never overlap.
- **Ready outputs in IDLE:**
  - `rd_rdy` = IDLE & !`ret_valid` & !`data_bvalid_o` & !(`WRITE_FIRST` & `wr_req`).
  - `wr_rdy` follows the same rule with read and write swapped.
- **Accept:** a request is accepted when req & rdy are both high. On accept the bridge latches {addr[31:5], 5'b0} into the address register. A write also latches `wr_data` into the line buffer. The beat counter clears to 0.
- **Read path:**
  - AR: `arvalid`=1 until `arready`, then go to R.
  - R: `rready`=1. Each `rvalid` stores `rdata` into `ret_data` word[cnt], and cnt increments.
  - `rlast` ends the burst regardless of cnt. Any words not received keep their old value.
  - On `rlast`, go to IDLE and register `ret_valid`=1 for exactly one cycle.
- **Write path:**
  - AW: `awvalid`=1 until `awready`, then go to W.
  - W: `wvalid`=1 and `wdata` = buffer word[cnt]. cnt increments on `wready`. `wlast`=(cnt==7).
  - When `wready` & `wlast`, go to B.
  - B: `bready`=1. On `bvalid`, go to IDLE and register `data_bvalid_o`=1 for one cycle.
- **Counter:** 3 bits and wraps. cnt is relevant only inside a burst.
- **AXI stability:** AR/AW/W payloads stay stable while valid is high and ready is low.
- **Reset (async assert):** every output goes to 0 (`arlen`/`awlen`/`wstrb` are constants), state goes to IDLE, and cnt and `ret_data` clear. A burst in progress is abandoned with no pulse. Deassertion is used synchronously.

## Timing

- **Read, accept at cycle T:**
  - `arvalid` is high from T+1.
  - With `arready` at T+1 and back-to-back beats from T+2 to T+9 (`rlast` at T+9), `ret_valid` is high at T+10.
  - Minimum latency is therefore 10 cycles from accept to `ret_valid`.
- **Write, accept at cycle T:**
  - `awvalid` is high from T+1.
  - With `wready` held high, beats run T+2 to T+9 and `bready` is high from T+10.
  - `bvalid` at T+10 gives `data_bvalid_o` at T+11.
- **Next accept:** the earliest next accept is the cycle after the completion pulse, because rdy is low during the pulse.
- **Stalls:** `arready`, `rvalid`, `wready` and `bvalid` stalls of any length extend the current state only.

## Test plan

- **Read burst:** `rd_addr`=0x1C00_0044, beats 0x100+i, zero stall. Expect `araddr`=0x1C00_0040, `arlen`=7, `ret_valid` at T+10, `ret_data` word i = 0x100+i, and exactly one pulse.
- **Write burst:** `wr_addr`=0x0000_2FFF, `wr_data` word i = 0xA0+i, `wready` low on every other cycle. Expect `awaddr`=0x2FE0, 8 beats of 0xA0..0xA7, `wlast` only on 0xA7, and one `data_bvalid_o` after `bvalid`.
- **Simultaneous requests:** `rd_req` and `wr_req` in the same cycle with `WRITE_FIRST`=1. The AW burst completes first; the AR burst starts only after `data_bvalid_o`.
- **Short read:** `rlast` on the 3rd beat. Expect `ret_valid` the next cycle with words 0–2 updated and words 3–7 unchanged.
- **Reset mid-write:** `reset` low during W beat 4. All outputs are 0 immediately, no `data_bvalid_o` is produced, and after release a fresh read completes normally.
